// File: rtl/converter_pkg.sv
// Shared definitions for the integer/float converters in the filter datapath.
package converter_pkg;

  localparam int FP_BIAS   = 127;
  localparam int FP_EXP_W  = 8;
  localparam int FP_MANT_W = 23;
  localparam int INT_W     = 32;

  // Exponent of a value whose leading one sits at bit INT_W-1.
  localparam logic [FP_EXP_W-1:0] FP_EXP_TOP = FP_EXP_W'(FP_BIAS + INT_W - 1);

  // Converter sequencing, shared by converter_i2f and converter_f2i.
  typedef enum logic [2:0] {
    GET_A     = 3'd0,
    CONVERT   = 3'd1,
    NORMALISE = 3'd2,
    ROUND     = 3'd3,
    PUT_Z     = 3'd4
  } conv_state_t;

endpackage

// File: rtl/lzc32.sv
// Combinational 32-bit leading-zero counter with an all-zero flag.
module lzc32 (
  input  logic [31:0] i_data,
  output logic [4:0]  o_count,
  output logic        o_zero
);

  logic found;

  // Scan from the MSB down; the first set bit fixes the count.
  always_comb begin
    o_count = 5'd0;
    found   = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (!found && i_data[i]) begin
        o_count = 5'(31 - i);
        found   = 1'b1;
      end
    end
    o_zero = ~|i_data;
  end

endmodule

// File: rtl/converter_i2f.sv
// Multi-cycle signed 32-bit integer to IEEE-754 single conversion, round-to-nearest-even.
module converter_i2f
  import converter_pkg::*;
(
  input  logic        i_CLK,
  input  logic        i_RSTN,
  input  logic [31:0] i_A,
  input  logic        i_A_STB,
  output logic        o_A_ACK,
  output logic [31:0] o_Z,
  output logic        o_Z_STB,
  input  logic        i_Z_ACK
);

  conv_state_t state_q, state_d;
  logic [31:0] a_q, a_d;
  logic        sign_q, sign_d;
  logic [31:0] mag_q, mag_d;
  logic        zero_q, zero_d;
  logic [30:0] norm_q, norm_d;
  logic [7:0]  exp_q, exp_d;
  logic [31:0] z_q, z_d;
  logic        ack_q, ack_d;
  logic        stb_q, stb_d;

  logic [4:0]  lz;
  logic        lz_zero;

  logic [22:0] mant;
  logic        guard_bit;
  logic        rnd_bit;
  logic        sticky_bit;
  logic        inc;
  logic        carry;
  logic [22:0] mant_rnd;
  logic [7:0]  exp_rnd;

  lzc32 u_lzc (
    .i_data  (mag_q),
    .o_count (lz),
    .o_zero  (lz_zero)
  );

  // Round the normalised magnitude to 23 fraction bits; a carry out bumps the exponent.
  always_comb begin
    mant             = norm_q[30:8];
    guard_bit        = norm_q[7];
    rnd_bit          = norm_q[6];
    sticky_bit       = |norm_q[5:0];
    inc              = guard_bit & (rnd_bit | sticky_bit | mant[0]);
    {carry, mant_rnd} = {1'b0, mant} + {23'd0, inc};
    exp_rnd          = exp_q + {7'd0, carry};
  end

  // Next-state and datapath updates for each conversion step.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    sign_d  = sign_q;
    mag_d   = mag_q;
    zero_d  = zero_q;
    norm_d  = norm_q;
    exp_d   = exp_q;
    z_d     = z_q;
    ack_d   = ack_q;
    stb_d   = stb_q;
    case (state_q)
      GET_A: begin
        if (!ack_q) begin
          ack_d = 1'b1;
        end else if (i_A_STB) begin
          a_d     = i_A;
          ack_d   = 1'b0;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        sign_d  = a_q[31];
        mag_d   = a_q[31] ? (~a_q + 32'd1) : a_q;
        zero_d  = (a_q == 32'd0);
        state_d = NORMALISE;
      end
      NORMALISE: begin
        norm_d  = 31'(mag_q << lz);
        exp_d   = lz_zero ? 8'd0 : (FP_EXP_TOP - {3'd0, lz});
        state_d = ROUND;
      end
      ROUND: begin
        z_d     = zero_q ? 32'd0 : {sign_q, exp_rnd, mant_rnd};
        state_d = PUT_Z;
      end
      PUT_Z: begin
        if (!stb_q) begin
          stb_d = 1'b1;
        end else if (i_Z_ACK) begin
          stb_d   = 1'b0;
          ack_d   = 1'b1;
          state_d = GET_A;
        end
      end
      default: begin
        state_d = GET_A;
        ack_d   = 1'b0;
        stb_d   = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset discards any operand in flight.
  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      state_q <= GET_A;
      a_q     <= 32'd0;
      sign_q  <= 1'b0;
      mag_q   <= 32'd0;
      zero_q  <= 1'b0;
      norm_q  <= 31'd0;
      exp_q   <= 8'd0;
      z_q     <= 32'd0;
      ack_q   <= 1'b0;
      stb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      sign_q  <= sign_d;
      mag_q   <= mag_d;
      zero_q  <= zero_d;
      norm_q  <= norm_d;
      exp_q   <= exp_d;
      z_q     <= z_d;
      ack_q   <= ack_d;
      stb_q   <= stb_d;
    end
  end

  assign o_A_ACK = ack_q;
  assign o_Z     = z_q;
  assign o_Z_STB = stb_q;

endmodule

// File: tb/tb_converter_i2f.sv
// Self-checking bench for converter_i2f: directed corner values plus a randomised soak.
module tb_converter_i2f;

  logic        i_CLK;
  logic        i_RSTN;
  logic [31:0] i_A;
  logic        i_A_STB;
  logic        o_A_ACK;
  logic [31:0] o_Z;
  logic        o_Z_STB;
  logic        i_Z_ACK;

  int vectors;
  int miscompares;

  converter_i2f dut (
    .i_CLK   (i_CLK),
    .i_RSTN  (i_RSTN),
    .i_A     (i_A),
    .i_A_STB (i_A_STB),
    .o_A_ACK (o_A_ACK),
    .o_Z     (o_Z),
    .o_Z_STB (o_Z_STB),
    .i_Z_ACK (i_Z_ACK)
  );

  // Free-running 100 MHz clock.
  initial begin
    i_CLK = 1'b0;
    forever #5 i_CLK = ~i_CLK;
  end

  // Hard stop in case a handshake never completes.
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference int->float: exact quotient/remainder rounding to nearest, ties to even.
  function automatic logic [31:0] refI2F(input logic [31:0] a);
    longint     sv;
    longint     m;
    longint     q;
    longint     r;
    longint     half;
    int         p;
    int         sh;
    int         e;
    logic       s;
    logic [63:0] qbits;
    logic [7:0]  ebits;
    sv = longint'($signed(a));
    s  = (sv < 0);
    m  = s ? -sv : sv;
    if (m == 0) return 32'h0000_0000;
    p = 0;
    while ((m >> (p + 1)) != 0) p++;
    e = 127 + p;
    if (p <= 23) begin
      q = m << (23 - p);
    end else begin
      sh   = p - 23;
      q    = m >> sh;
      r    = m - (q << sh);
      half = longint'(1) << (sh - 1);
      if (r > half || (r == half && q[0])) q = q + 1;
      if (q == (longint'(1) << 24)) begin
        q = q >> 1;
        e = e + 1;
      end
    end
    qbits = 64'(q);
    ebits = 8'(e);
    return {s, ebits, qbits[22:0]};
  endfunction

  // One comparison: counts it, and reports a miscompare.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Bounded wait that turns a timeout into a counted failure.
  task automatic timeoutFail(input string tag);
    vectors++;
    miscompares++;
    $error("[TB] FAIL %s: observed timeout expected handshake", tag);
  endtask

  // Push one operand through the full handshake and check latency and result.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] expected,
                               input int stallIn, input int stallOut);
    int t;
    int n;
    repeat (stallIn) @(negedge i_CLK);
    t = 0;
    while (!o_A_ACK && t < 50) begin
      @(negedge i_CLK);
      t++;
    end
    if (t >= 50) timeoutFail("a_ack_wait");
    i_A     = a;
    i_A_STB = 1'b1;
    @(posedge i_CLK);
    @(negedge i_CLK);
    i_A_STB = 1'b0;
    i_A     = $urandom;
    checkOutput("ack_low_after_accept", {31'd0, o_A_ACK}, 32'd0);
    n = 0;
    while (!o_Z_STB && n < 50) begin
      @(negedge i_CLK);
      n++;
    end
    if (n >= 50) timeoutFail("z_stb_wait");
    checkOutput("latency", n, 32'd4);
    checkOutput("result", o_Z, expected);
    repeat (stallOut) @(negedge i_CLK);
    checkOutput("result_held", o_Z, expected);
    i_Z_ACK = 1'b1;
    @(posedge i_CLK);
    @(negedge i_CLK);
    i_Z_ACK = 1'b0;
    checkOutput("stb_low_after_ack", {31'd0, o_Z_STB}, 32'd0);
    checkOutput("ack_high_after_ack", {31'd0, o_A_ACK}, 32'd1);
  endtask

  logic [31:0] held;
  logic [31:0] r;
  int          t;

  initial begin
    vectors     = 0;
    miscompares = 0;
    i_RSTN  = 1'b0;
    i_A     = 32'd0;
    i_A_STB = 1'b0;
    i_Z_ACK = 1'b0;

    #1;
    checkOutput("reset_z", o_Z, 32'd0);
    checkOutput("reset_z_stb", {31'd0, o_Z_STB}, 32'd0);
    checkOutput("reset_a_ack", {31'd0, o_A_ACK}, 32'd0);
    repeat (2) @(negedge i_CLK);
    i_RSTN = 1'b1;
    #1;
    checkOutput("ack_before_first_edge", {31'd0, o_A_ACK}, 32'd0);
    @(negedge i_CLK);
    checkOutput("ack_after_first_edge", {31'd0, o_A_ACK}, 32'd1);

    $display("[TB] basic and extreme values");
    applyStimulus(32'd1,         32'h3F80_0000, 0, 0);
    applyStimulus(32'hFFFF_FFFF, 32'hBF80_0000, 0, 0);
    applyStimulus(32'd0,         32'h0000_0000, 0, 0);
    applyStimulus(32'h7FFF_FFFF, 32'h4F00_0000, 0, 0);
    applyStimulus(32'h8000_0000, 32'hCF00_0000, 0, 0);
    applyStimulus(32'd16777217,  32'h4B80_0000, 0, 0);
    applyStimulus(32'd16777219,  32'h4B80_0002, 0, 0);
    applyStimulus(32'd123456789, 32'h4CEB_79A3, 1, 2);

    $display("[TB] back-pressure");
    i_A = 32'd1000;
    t = 0;
    while (!o_A_ACK && t < 50) begin
      @(negedge i_CLK);
      t++;
    end
    if (t >= 50) timeoutFail("bp_ack_wait");
    i_A_STB = 1'b1;
    @(posedge i_CLK);
    @(negedge i_CLK);
    i_A_STB = 1'b0;
    t = 0;
    while (!o_Z_STB && t < 50) begin
      @(negedge i_CLK);
      t++;
    end
    if (t >= 50) timeoutFail("bp_stb_wait");
    held = o_Z;
    checkOutput("bp_result", held, 32'h447A_0000);
    for (int c = 0; c < 20; c++) begin
      i_A     = $urandom;
      i_A_STB = c[0];
      @(negedge i_CLK);
      checkOutput("bp_z_stable", o_Z, 32'h447A_0000);
      checkOutput("bp_stb_stable", {31'd0, o_Z_STB}, 32'd1);
      checkOutput("bp_ack_low", {31'd0, o_A_ACK}, 32'd0);
    end
    i_A_STB = 1'b0;
    i_Z_ACK = 1'b1;
    @(posedge i_CLK);
    @(negedge i_CLK);
    i_Z_ACK = 1'b0;
    checkOutput("bp_ack_return", {31'd0, o_A_ACK}, 32'd1);
    checkOutput("bp_stb_drop", {31'd0, o_Z_STB}, 32'd0);
    applyStimulus(32'd3, 32'h4040_0000, 0, 0);

    $display("[TB] reset mid-operation");
    i_A     = 32'd12345;
    i_A_STB = 1'b1;
    @(posedge i_CLK);
    @(negedge i_CLK);
    i_A_STB = 1'b0;
    @(negedge i_CLK);
    i_RSTN = 1'b0;
    #1;
    checkOutput("midreset_z", o_Z, 32'd0);
    checkOutput("midreset_stb", {31'd0, o_Z_STB}, 32'd0);
    checkOutput("midreset_ack", {31'd0, o_A_ACK}, 32'd0);
    @(negedge i_CLK);
    i_RSTN = 1'b1;
    repeat (6) begin
      @(negedge i_CLK);
      checkOutput("midreset_no_partial", {31'd0, o_Z_STB}, 32'd0);
    end
    applyStimulus(32'd2, 32'h4000_0000, 0, 0);

    $display("[TB] random soak");
    for (int k = 0; k < 1500; k++) begin
      case ($urandom_range(0, 3))
        0:       r = $urandom;
        1:       r = $urandom >> $urandom_range(0, 31);
        2:       r = -($urandom >> $urandom_range(0, 31));
        default: r = ($urandom_range(0, 1) ? 32'h0100_0000 : 32'h0200_0000) + $urandom_range(0, 8);
      endcase
      applyStimulus(r, refI2F(r), $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
